// File: rtl/pll_lock_ctrl_if.sv
// Signal bundle between the PLL lock sequencer and its surroundings.
// The slave side is the sequencer; the master side drives lock and relock requests.
interface pll_lock_ctrl_if #(
  parameter int unsigned MAX_RETRY = 3
);
  localparam int unsigned RetryW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  logic              lock;
  logic              relock_req;
  logic              pll_reset;
  logic              sys_rst;
  logic              locked;
  logic              fail;
  logic [RetryW-1:0] retry_cnt;
  logic [7:0]        loss_cnt;

  modport master (
    output lock, relock_req,
    input  pll_reset, sys_rst, locked, fail, retry_cnt, loss_cnt
  );

  modport slave (
    input  lock, relock_req,
    output pll_reset, sys_rst, locked, fail, retry_cnt, loss_cnt
  );
endinterface

// File: rtl/pll_lock_ctrl.sv
// PLL reset/lock sequencer: pulses PLL reset, waits for a debounced lock with timeout and
// bounded retry, and holds the downstream pipeline in reset until the PLL output is stable.
module pll_lock_ctrl #(
  parameter int unsigned RST_CYCLES   = 16,
  parameter int unsigned LOCK_TIMEOUT = 65536,
  parameter int unsigned LOCK_STABLE  = 1024,
  parameter int unsigned MAX_RETRY    = 3
) (
  input logic            clkin,
  input logic            reset,
  pll_lock_ctrl_if.slave bus
);
  localparam int unsigned PrstW  = $clog2(RST_CYCLES + 1);
  localparam int unsigned TmrW   = $clog2(LOCK_TIMEOUT);
  localparam int unsigned StabW  = $clog2(LOCK_STABLE + 1);
  localparam int unsigned RetryW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [2:0] {StPrst, StWait, StStab, StRun, StFail} state_e;

  state_e            state_q, state_d;
  logic [PrstW-1:0]  prst_cnt_q, prst_cnt_d;
  logic [TmrW-1:0]   tmr_q, tmr_d;
  logic [StabW-1:0]  stab_cnt_q, stab_cnt_d;
  logic [RetryW-1:0] retry_q, retry_d;
  logic [7:0]        loss_q, loss_d;
  logic              lock_m, lock_s;
  logic              pll_reset_q, sys_rst_q, locked_q, fail_q;
  logic              timeout, clear_timers;

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      lock_m <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      lock_m <= bus.lock;
      lock_s <= lock_m;
    end
  end

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      state_q    <= StPrst;
      prst_cnt_q <= '0;
      tmr_q      <= '0;
      stab_cnt_q <= '0;
      retry_q    <= '0;
      loss_q     <= '0;
    end else begin
      state_q    <= state_d;
      prst_cnt_q <= prst_cnt_d;
      tmr_q      <= tmr_d;
      stab_cnt_q <= stab_cnt_d;
      retry_q    <= retry_d;
      loss_q     <= loss_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    prst_cnt_d   = prst_cnt_q;
    tmr_d        = tmr_q;
    stab_cnt_d   = stab_cnt_q;
    retry_d      = retry_q;
    loss_d       = loss_q;
    timeout      = 1'b0;
    clear_timers = 1'b0;
    if (bus.relock_req) begin
      state_d      = StPrst;
      retry_d      = '0;
      clear_timers = 1'b1;
    end else begin
      unique case (state_q)
        StPrst: begin
          if (prst_cnt_q == PrstW'(RST_CYCLES - 1)) begin
            state_d      = StWait;
            clear_timers = 1'b1;
          end else begin
            prst_cnt_d = prst_cnt_q + PrstW'(1);
          end
        end
        StWait: begin
          tmr_d = tmr_q + TmrW'(1);
          if (tmr_q == TmrW'(LOCK_TIMEOUT - 1)) begin
            timeout = 1'b1;
          end else if (lock_s) begin
            state_d    = StStab;
            stab_cnt_d = '0;
          end
        end
        StStab: begin
          tmr_d = tmr_q + TmrW'(1);
          // Completing the stable count beats a timeout landing on the same cycle.
          if (lock_s && (stab_cnt_q == StabW'(LOCK_STABLE - 1))) begin
            state_d      = StRun;
            retry_d      = '0;
            clear_timers = 1'b1;
          end else if (tmr_q == TmrW'(LOCK_TIMEOUT - 1)) begin
            timeout = 1'b1;
          end else if (!lock_s) begin
            state_d    = StWait;
            stab_cnt_d = '0;
          end else begin
            stab_cnt_d = stab_cnt_q + StabW'(1);
          end
        end
        StRun: begin
          if (!lock_s) begin
            state_d      = StPrst;
            clear_timers = 1'b1;
            if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
          end
        end
        StFail:  state_d = StFail;
        default: state_d = StPrst;
      endcase
      if (timeout) begin
        clear_timers = 1'b1;
        if (retry_q == RetryW'(MAX_RETRY)) begin
          state_d = StFail;
        end else begin
          retry_d = retry_q + RetryW'(1);
          state_d = StPrst;
        end
      end
    end
    if (clear_timers) begin
      prst_cnt_d = '0;
      tmr_d      = '0;
      stab_cnt_d = '0;
    end
  end

  // Outputs are registered from the next state so they change with state_q, glitch-free.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      pll_reset_q <= 1'b1;
      sys_rst_q   <= 1'b1;
      locked_q    <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      pll_reset_q <= (state_d == StPrst) || (state_d == StFail);
      sys_rst_q   <= (state_d != StRun);
      locked_q    <= (state_d == StRun);
      fail_q      <= (state_d == StFail);
    end
  end

  assign bus.pll_reset = pll_reset_q;
  assign bus.sys_rst   = sys_rst_q;
  assign bus.locked    = locked_q;
  assign bus.fail      = fail_q;
  assign bus.retry_cnt = retry_q;
  assign bus.loss_cnt  = loss_q;
endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Self-checking bench for pll_lock_ctrl: directed scenarios plus random lock/relock
// stimulus, all outputs compared every cycle against a phase-level reference model.
module tb_pll_lock_ctrl;
  localparam int unsigned RstCycles   = 4;
  localparam int unsigned LockTimeout = 20;
  localparam int unsigned LockStable  = 8;
  localparam int unsigned MaxRetry    = 2;

  // Model phases: WAIT and STAB are folded into one acquire phase tracked by run length.
  localparam int ModePulse  = 0;
  localparam int ModeAcq    = 1;
  localparam int ModeRun    = 2;
  localparam int ModeFailed = 3;

  // Lock sampled -> decision: 2 sync edges, 1 WAIT detect edge, LockStable STAB edges.
  localparam int RiseToRun  = 2 + 1 + LockStable;
  localparam int DropToRst  = 3;

  logic clkin = 1'b0;
  logic reset = 1'b1;

  pll_lock_ctrl_if #(.MAX_RETRY(MaxRetry)) bus ();

  pll_lock_ctrl #(
    .RST_CYCLES  (RstCycles),
    .LOCK_TIMEOUT(LockTimeout),
    .LOCK_STABLE (LockStable),
    .MAX_RETRY   (MaxRetry)
  ) dut (
    .clkin(clkin),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clkin = ~clkin;

  int n_total = 0;
  int n_bad   = 0;

  int m_mode, m_age, m_run, m_retry, m_loss;
  bit m_h1, m_h2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_mode  = ModePulse;
    m_age   = 0;
    m_run   = 0;
    m_retry = 0;
    m_loss  = 0;
    m_h1    = 1'b0;
    m_h2    = 1'b0;
  endfunction

  function automatic void model_step();
    bit ls;
    ls   = m_h2;
    m_h2 = m_h1;
    m_h1 = bus.lock;
    if (bus.relock_req) begin
      m_mode  = ModePulse;
      m_age   = 0;
      m_retry = 0;
    end else begin
      case (m_mode)
        ModePulse: begin
          if (m_age == RstCycles - 1) begin
            m_mode = ModeAcq;
            m_age  = 0;
            m_run  = 0;
          end else begin
            m_age++;
          end
        end
        ModeAcq: begin
          m_run = ls ? m_run + 1 : 0;
          if (m_run == LockStable + 1) begin
            m_mode  = ModeRun;
            m_retry = 0;
          end else if (m_age == LockTimeout - 1) begin
            if (m_retry == MaxRetry) begin
              m_mode = ModeFailed;
            end else begin
              m_retry++;
              m_mode = ModePulse;
              m_age  = 0;
            end
          end else begin
            m_age++;
          end
        end
        ModeRun: begin
          if (!ls) begin
            m_loss = (m_loss < 255) ? m_loss + 1 : 255;
            m_mode = ModePulse;
            m_age  = 0;
          end
        end
        default: ;
      endcase
    end
  endfunction

  task automatic check_outs();
    check("pll_reset", 32'(bus.pll_reset), 32'(m_mode == ModePulse || m_mode == ModeFailed));
    check("sys_rst", 32'(bus.sys_rst), 32'(m_mode != ModeRun));
    check("locked", 32'(bus.locked), 32'(m_mode == ModeRun));
    check("fail", 32'(bus.fail), 32'(m_mode == ModeFailed));
    check("retry_cnt", 32'(bus.retry_cnt), 32'(m_retry));
    check("loss_cnt", 32'(bus.loss_cnt), 32'(m_loss));
  endtask

  task automatic tick();
    @(posedge clkin);
    if (reset) model_reset();
    else model_step();
    @(negedge clkin);
    check_outs();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic logic pick(input int sel);
    case (sel)
      0:       return bus.sys_rst;
      1:       return bus.pll_reset;
      default: return bus.fail;
    endcase
  endfunction

  // Ticks until the selected DUT output takes the value; the tick count is the comparison.
  task automatic wait_for(input string tag, input int sel, input logic val, input int exp_n);
    int n;
    n = 0;
    while (pick(sel) !== val && n < 200) begin
      tick();
      n++;
    end
    check(tag, 32'(n), 32'(exp_n));
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, total=%0d", n_total);
    $fatal(1, "watchdog");
  end

  initial begin
    int d;
    bus.lock       = 1'b0;
    bus.relock_req = 1'b0;
    model_reset();
    repeat (3) @(negedge clkin);
    check_outs();

    // 1: normal lock
    reset = 1'b0;
    wait_for("prst_width", 1, 1'b0, RstCycles);
    ticks(6);
    bus.lock = 1'b1;
    wait_for("rise_to_run", 0, 1'b0, RiseToRun);
    check("run_locked", 32'(bus.locked), 32'd1);
    check("run_retry", 32'(bus.retry_cnt), 32'd0);

    // 2: chatter that still locks, then chatter that runs into the timeout
    bus.lock = 1'b0;
    wait_for("loss_latency", 0, 1'b1, DropToRst);
    check("loss_one", 32'(bus.loss_cnt), 32'd1);
    wait_for("prst_width2", 1, 1'b0, RstCycles);
    bus.lock = 1'b1;
    ticks(5);
    bus.lock = 1'b0;
    tick();
    bus.lock = 1'b1;
    wait_for("chatter_run", 0, 1'b0, RiseToRun);

    bus.lock = 1'b0;
    wait_for("loss_latency2", 0, 1'b1, DropToRst);
    wait_for("prst_width3", 1, 1'b0, RstCycles);
    ticks(6);
    bus.lock = 1'b1;
    ticks(5);
    bus.lock = 1'b0;
    tick();
    bus.lock = 1'b1;
    // Second rise sampled at acquire age 12, timeout decision at age LockTimeout-1.
    wait_for("chatter_timeout", 1, 1'b1, LockTimeout - 12);
    check("chatter_retry", 32'(bus.retry_cnt), 32'd1);
    wait_for("retry_run", 0, 1'b0, RstCycles + 1 + LockStable);
    check("retry_cleared", 32'(bus.retry_cnt), 32'd0);

    // 3: timeouts to FAIL
    bus.lock = 1'b0;
    wait_for("loss_latency3", 0, 1'b1, DropToRst);
    for (int r = 1; r <= MaxRetry; r++) begin
      wait_for("retry_pulse", 1, 1'b0, RstCycles);
      wait_for("retry_gap", 1, 1'b1, LockTimeout);
      check("retry_step", 32'(bus.retry_cnt), 32'(r));
    end
    wait_for("last_pulse", 1, 1'b0, RstCycles);
    wait_for("to_fail", 2, 1'b1, LockTimeout);
    ticks(30);
    check("fail_held", 32'(bus.fail), 32'd1);
    check("fail_pll_reset", 32'(bus.pll_reset), 32'd1);
    check("fail_sys_rst", 32'(bus.sys_rst), 32'd1);

    // 5: relock_req from FAIL and from RUN
    bus.relock_req = 1'b1;
    tick();
    bus.relock_req = 1'b0;
    check("relock_fail_retry", 32'(bus.retry_cnt), 32'd0);
    check("relock_fail_loss", 32'(bus.loss_cnt), 32'd3);
    wait_for("relock_pulse", 1, 1'b0, RstCycles);
    ticks(2);
    bus.lock = 1'b1;
    wait_for("relock_run", 0, 1'b0, RiseToRun);
    ticks(5);
    bus.relock_req = 1'b1;
    tick();
    bus.relock_req = 1'b0;
    check("relock_run_prst", 32'(bus.pll_reset), 32'd1);
    check("relock_run_loss", 32'(bus.loss_cnt), 32'd3);
    wait_for("relock_pulse2", 1, 1'b0, RstCycles - 1 + 1);
    wait_for("relock_run2", 0, 1'b0, 1 + LockStable);

    // 6: async reset in STAB
    bus.lock = 1'b0;
    wait_for("loss_latency4", 0, 1'b1, DropToRst);
    wait_for("prst_width4", 1, 1'b0, RstCycles);
    bus.lock = 1'b1;
    ticks(5);
    #2 reset = 1'b1;
    model_reset();
    #1;
    check_outs();
    check("areset_loss", 32'(bus.loss_cnt), 32'd0);
    check("areset_pll_reset", 32'(bus.pll_reset), 32'd1);
    ticks(2);
    reset = 1'b0;
    wait_for("post_reset_pulse", 1, 1'b0, RstCycles);
    wait_for("post_reset_run", 0, 1'b0, 1 + LockStable);

    // Random lock chatter and occasional relock requests
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 19) == 0) bus.lock = ~bus.lock;
      bus.relock_req = ($urandom_range(0, 99) == 0);
      tick();
    end
    bus.relock_req = 1'b0;

    // 4: repeated loss in RUN, loss_cnt saturates
    bus.lock       = 1'b1;
    bus.relock_req = 1'b1;
    tick();
    bus.relock_req = 1'b0;
    for (int i = 0; i < 100 && m_mode != ModeRun; i++) tick();
    check("enter_run", 32'(bus.locked), 32'd1);
    for (int i = 0; i < 300; i++) begin
      bus.lock = 1'b0;
      wait_for("loop_loss", 0, 1'b1, DropToRst);
      d = int'($urandom_range(0, 8));
      wait_for("loop_pulse", 1, 1'b0, RstCycles);
      ticks(d);
      bus.lock = 1'b1;
      wait_for("loop_run", 0, 1'b0, RiseToRun);
      ticks(int'($urandom_range(1, 4)));
    end
    check("loss_saturated", 32'(bus.loss_cnt), 32'd255);
    check("loop_retry", 32'(bus.retry_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
